// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encoding, block geometry, memory latency.
package mem_arbiter_pkg;

    localparam int BLK_OFS_W   = 4;
    localparam int WORD_IDX_W  = 3;
    localparam int BLK_WRDS    = 1 << WORD_IDX_W;
    localparam int MEM_LAT_DEF = 4;

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLK_WRDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    function automatic logic [WORD_IDX_W-1:0] next_idx(input logic [WORD_IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_pldff.sv
// Plain D register with synchronous active-high clear; holds every piece of arbiter state.
module mem_arbiter_pldff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-fills, D-fills and D write-through stores; sequences 8-word fills.
//   state    | meaning
//   ST_IDLE  | sample requests, grant store first, then fills with I/D alternation on conflict
//   ST_STORE | single write cycle, dc_wr_done pulses
//   ST_FILL  | issue 8 pipelined reads, steer 8 returning words to tgt_d side, done on last word
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_miss,
    input  logic [ADDR_W-1:0]     ic_miss_addr,
    input  logic                  dc_miss,
    input  logic [ADDR_W-1:0]     dc_miss_addr,
    input  logic                  dc_wr,
    input  logic [ADDR_W-1:0]     dc_wr_addr,
    input  logic [DATA_W-1:0]     dc_wr_data,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  ic_fill_we,
    output logic                  dc_fill_we,
    output logic                  ic_fill_done,
    output logic                  dc_fill_done,
    output logic                  dc_wr_done,
    output logic                  ic_stall,
    output logic                  dc_stall
);

    logic [1:0]            state_q;
    state_t                state;
    state_t                state_n;
    logic [WORD_IDX_W-1:0] iss_cnt, iss_cnt_n;
    logic                  iss_done, iss_done_n;
    logic [WORD_IDX_W-1:0] rx_cnt, rx_cnt_n;
    logic [ADDR_W-1:0]     blk_addr, blk_addr_n;
    logic                  tgt_d, tgt_d_n;
    logic                  last_d, last_d_n;
    logic                  grant_d;

    assign state = state_t'(state_q);

    mem_arbiter_pldff #(.W(2))          u_state    (.clk(clk), .rst(rst), .d(state_n),    .q(state_q));
    mem_arbiter_pldff #(.W(WORD_IDX_W)) u_iss_cnt  (.clk(clk), .rst(rst), .d(iss_cnt_n),  .q(iss_cnt));
    mem_arbiter_pldff #(.W(1))          u_iss_done (.clk(clk), .rst(rst), .d(iss_done_n), .q(iss_done));
    mem_arbiter_pldff #(.W(WORD_IDX_W)) u_rx_cnt   (.clk(clk), .rst(rst), .d(rx_cnt_n),   .q(rx_cnt));
    mem_arbiter_pldff #(.W(ADDR_W))     u_blk_addr (.clk(clk), .rst(rst), .d(blk_addr_n), .q(blk_addr));
    mem_arbiter_pldff #(.W(1))          u_tgt_d    (.clk(clk), .rst(rst), .d(tgt_d_n),    .q(tgt_d));
    mem_arbiter_pldff #(.W(1))          u_last_d   (.clk(clk), .rst(rst), .d(last_d_n),   .q(last_d));

    // Block offset bits are rebuilt from iss_cnt, so the latched low bits never reach memory.
    logic unused_blk_ofs;
    assign unused_blk_ofs = ^blk_addr[BLK_OFS_W-1:0];

    always_comb begin
        state_n      = state;
        iss_cnt_n    = iss_cnt;
        iss_done_n   = iss_done;
        rx_cnt_n     = rx_cnt;
        blk_addr_n   = blk_addr;
        tgt_d_n      = tgt_d;
        last_d_n     = last_d;
        grant_d      = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ic_fill_we   = 1'b0;
        dc_fill_we   = 1'b0;
        ic_fill_done = 1'b0;
        dc_fill_done = 1'b0;
        dc_wr_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (dc_wr) begin
                    state_n = ST_STORE;
                end else if (ic_miss || dc_miss) begin
                    // On a fill conflict, whoever did not win last time goes first.
                    grant_d    = dc_miss & (~ic_miss | ~last_d);
                    state_n    = ST_FILL;
                    tgt_d_n    = grant_d;
                    last_d_n   = grant_d;
                    blk_addr_n = grant_d ? dc_miss_addr : ic_miss_addr;
                    iss_cnt_n  = '0;
                    iss_done_n = 1'b0;
                    rx_cnt_n   = '0;
                end
            end

            ST_STORE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = dc_wr_addr;
                mem_wdata  = dc_wr_data;
                dc_wr_done = 1'b1;
                state_n    = ST_IDLE;
            end

            ST_FILL: begin
                if (!iss_done) begin
                    mem_en   = 1'b1;
                    mem_addr = {blk_addr[ADDR_W-1:BLK_OFS_W], iss_cnt, 1'b0};
                    if (iss_cnt == LAST_WORD) iss_done_n = 1'b1;
                    else                      iss_cnt_n  = next_idx(iss_cnt);
                end
                if (mem_valid) begin
                    ic_fill_we = ~tgt_d;
                    dc_fill_we = tgt_d;
                    if (rx_cnt == LAST_WORD) begin
                        ic_fill_done = ~tgt_d;
                        dc_fill_done = tgt_d;
                        state_n      = ST_IDLE;
                        rx_cnt_n     = '0;
                        iss_cnt_n    = '0;
                        iss_done_n   = 1'b0;
                    end else begin
                        rx_cnt_n = next_idx(rx_cnt);
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign fill_data = mem_rdata;
    assign fill_word = rx_cnt;
    assign ic_stall  = ic_miss & ~ic_fill_done;
    assign dc_stall  = (dc_miss & ~dc_fill_done) | (dc_wr & ~dc_wr_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level timing model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_miss, dc_miss, dc_wr;
    logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
    logic        mem_en, mem_wr, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_word;
    logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, ic_stall, dc_stall;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_wr(dc_wr), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done), .dc_wr_done(dc_wr_done),
        .ic_stall(ic_stall), .dc_stall(dc_stall)
    );

    // Pipelined memory: a read strobed in cycle n returns in cycle n+MEM_LAT_DEF, ignoring rst.
    logic        pv [MEM_LAT_DEF] = '{default: 1'b0};
    logic [15:0] pa [MEM_LAT_DEF] = '{default: 16'h0};

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        pv[0] <= mem_en & ~mem_wr;
        pa[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT_DEF; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign mem_valid = pv[MEM_LAT_DEF-1];
    assign mem_rdata = mem_f(pa[MEM_LAT_DEF-1]);

    int n_tests = 0;
    int n_fail  = 0;
    int now;

    logic        ic_req, dc_req, wr_req;
    logic [15:0] ic_a, dc_a, wr_a, wr_d;
    int          ic_done_at, dc_done_at, wr_done_at;
    bit          rnd_mode;
    bit          m_last_d;
    int          free_at;

    logic [15:0] e_rd [int];
    logic [31:0] e_st [int];
    logic [19:0] e_we [int];

    int obs_ic_done, obs_dc_done, obs_wr_done, n_valid_seen, n_we_seen;

    task automatic model_grant();
        bit          d;
        logic [15:0] base;
        int          done_cyc;
        if (now < free_at) return;
        if (wr_req) begin
            e_st[now+1] = {wr_a, wr_d};
            wr_done_at  = now + 1;
            free_at     = now + 2;
        end else if (ic_req || dc_req) begin
            d        = (ic_req && dc_req) ? !m_last_d : dc_req;
            m_last_d = d;
            base     = (d ? dc_a : ic_a) & 16'hFFF0;
            for (int i = 0; i < BLK_WRDS; i++) begin
                e_rd[now+1+i]             = base + 16'(2*i);
                e_we[now+1+MEM_LAT_DEF+i] = {d, 3'(i), base + 16'(2*i)};
            end
            done_cyc = now + MEM_LAT_DEF + BLK_WRDS;
            if (d) dc_done_at = done_cyc;
            else   ic_done_at = done_cyc;
            free_at = done_cyc + 1;
        end
    endtask

    task automatic model_reset();
        int keys[$];
        foreach (e_rd[k]) if (k > now) keys.push_back(k);
        foreach (keys[j]) e_rd.delete(keys[j]);
        keys.delete();
        foreach (e_st[k]) if (k > now) keys.push_back(k);
        foreach (keys[j]) e_st.delete(keys[j]);
        keys.delete();
        foreach (e_we[k]) if (k > now) keys.push_back(k);
        foreach (keys[j]) e_we.delete(keys[j]);
        if (ic_done_at > now) ic_done_at = -10;
        if (dc_done_at > now) dc_done_at = -10;
        if (wr_done_at > now) wr_done_at = -10;
        free_at  = now + 1;
        m_last_d = 1'b0;
    endtask

    // One clock cycle: requester behaviour, model update, output check, advance.
    task automatic step(input bit do_rst);
        logic        has_rd, has_st, has_we, side, icd, dcd, wrd;
        logic [2:0]  word;
        logic [15:0] waddr, exp_addr, exp_wdata;
        logic [19:0] we_ent;
        logic [31:0] st_ent;
        logic [8:0]  exp_ctl, got_ctl;

        if (ic_req && now == ic_done_at + 1) ic_req = 1'b0;
        if (dc_req && now == dc_done_at + 1) dc_req = 1'b0;
        if (wr_req && now == wr_done_at + 1) wr_req = 1'b0;
        if (rnd_mode) begin
            if (!ic_req && now != ic_done_at + 1 && $urandom_range(0, 9) == 0) begin
                ic_req = 1'b1; ic_a = 16'($urandom);
            end
            if (!dc_req && now != dc_done_at + 1 && $urandom_range(0, 9) == 0) begin
                dc_req = 1'b1; dc_a = 16'($urandom);
            end
            if (!wr_req && now != wr_done_at + 1 && $urandom_range(0, 14) == 0) begin
                wr_req = 1'b1; wr_a = 16'($urandom); wr_d = 16'($urandom);
            end
        end
        rst = do_rst;
        ic_miss = ic_req; ic_miss_addr = ic_a;
        dc_miss = dc_req; dc_miss_addr = dc_a;
        dc_wr = wr_req; dc_wr_addr = wr_a; dc_wr_data = wr_d;
        if (do_rst) model_reset();
        else        model_grant();

        has_rd = e_rd.exists(now);
        has_st = e_st.exists(now);
        has_we = e_we.exists(now);
        we_ent = has_we ? e_we[now] : 20'h0;
        st_ent = has_st ? e_st[now] : 32'h0;
        side   = we_ent[19];
        word   = we_ent[18:16];
        waddr  = we_ent[15:0];
        exp_addr  = has_rd ? e_rd[now] : st_ent[31:16];
        exp_wdata = st_ent[15:0];
        icd = has_we & ~side & (word == 3'd7);
        dcd = has_we &  side & (word == 3'd7);
        wrd = has_st;
        exp_ctl = {has_rd | has_st, has_st, has_we & ~side, has_we & side, icd, dcd, wrd,
                   ic_req & ~icd, (dc_req & ~dcd) | (wr_req & ~wrd)};

        @(negedge clk);
        got_ctl = {mem_en, mem_wr, ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done,
                   ic_stall, dc_stall};
        n_tests++;
        if (got_ctl !== exp_ctl) begin
            n_fail++;
            $display("FAIL ctl cyc=%0d got=%b exp=%b (en wr icwe dcwe icdn dcdn wrdn ics dcs)", now, got_ctl, exp_ctl);
        end
        n_tests++;
        if (mem_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL mem_addr cyc=%0d got=%h exp=%h", now, mem_addr, exp_addr);
        end
        n_tests++;
        if (mem_wdata !== exp_wdata) begin
            n_fail++;
            $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", now, mem_wdata, exp_wdata);
        end
        if (has_we) begin
            n_tests++;
            if (fill_word !== word || fill_data !== mem_f(waddr)) begin
                n_fail++;
                $display("FAIL fill cyc=%0d got word=%0d data=%h exp word=%0d data=%h",
                         now, fill_word, fill_data, word, mem_f(waddr));
            end
        end
        if (ic_fill_done) obs_ic_done = now;
        if (dc_fill_done) obs_dc_done = now;
        if (dc_wr_done)   obs_wr_done = now;
        if (mem_valid)    n_valid_seen++;
        if (ic_fill_we || dc_fill_we) n_we_seen++;
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ic_miss = 0; dc_miss = 0; dc_wr = 0;
        ic_miss_addr = 0; dc_miss_addr = 0; dc_wr_addr = 0; dc_wr_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({mem_en, mem_wr, ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done,
             ic_stall, dc_stall} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b exp=0", {mem_en, mem_wr, ic_fill_we, dc_fill_we,
                     ic_fill_done, dc_fill_done, dc_wr_done, ic_stall, dc_stall});
        end
        n_tests++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
        end
        n_tests++;
        if (fill_word !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fill_word got=%0d exp=0", fill_word);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0; free_at = 0; m_last_d = 0;
        ic_req = 0; dc_req = 0; wr_req = 0;
        ic_a = 0; dc_a = 0; wr_a = 0; wr_d = 0;
        ic_done_at = -10; dc_done_at = -10; wr_done_at = -10;
    endtask

    task automatic test_i_fill();
        int t0 = now;
        ic_a = 16'h1236; ic_req = 1'b1;
        repeat (16) step(1'b0);
        n_tests++;
        if (obs_ic_done !== t0 + 12) begin
            n_fail++;
            $display("FAIL i_fill_done_cycle got=%0d exp=%0d", obs_ic_done - t0, 12);
        end
    endtask

    task automatic test_store();
        int t0 = now;
        wr_a = 16'h00A4; wr_d = 16'hBEEF; wr_req = 1'b1;
        repeat (4) step(1'b0);
        n_tests++;
        if (obs_wr_done !== t0 + 1) begin
            n_fail++;
            $display("FAIL store_done_cycle got=%0d exp=1", obs_wr_done - t0);
        end
    endtask

    task automatic test_conflict();
        int t0;
        for (int r = 0; r < 3; r++) begin
            t0 = now;
            ic_a = 16'h2000 + 16'(r * 16'h0110); dc_a = 16'h3018 + 16'(r * 16'h0220);
            ic_req = 1'b1; dc_req = 1'b1;
            repeat (30) step(1'b0);
            // Pairs 0 and 1 follow a fill won by I (D goes first); pair 2 follows a D-won fill.
            n_tests++;
            if (r < 2 ? (obs_dc_done !== t0 + 12 || obs_ic_done !== t0 + 25)
                      : (obs_ic_done !== t0 + 12 || obs_dc_done !== t0 + 25)) begin
                n_fail++;
                $display("FAIL conflict_order pair=%0d got ic=%0d dc=%0d", r,
                         obs_ic_done - t0, obs_dc_done - t0);
            end
            if (r == 1) begin
                t0 = now;
                dc_a = 16'h5550; dc_req = 1'b1;
                repeat (15) step(1'b0);
            end
        end
    endtask

    task automatic test_store_then_fill();
        int t0 = now;
        wr_a = 16'h0F02; wr_d = 16'h1357; wr_req = 1'b1;
        ic_a = 16'h7A4C; ic_req = 1'b1;
        repeat (18) step(1'b0);
        n_tests++;
        if (obs_wr_done !== t0 + 1 || obs_ic_done !== t0 + 14) begin
            n_fail++;
            $display("FAIL store_first got wr=%0d ic=%0d exp wr=1 ic=14", obs_wr_done - t0, obs_ic_done - t0);
        end
    endtask

    task automatic test_drop_mid_fill();
        int t0 = now;
        ic_a = 16'h8886; ic_req = 1'b1;
        repeat (4) step(1'b0);
        ic_req = 1'b0;
        repeat (12) step(1'b0);
        n_tests++;
        if (obs_ic_done !== t0 + 12) begin
            n_fail++;
            $display("FAIL drop_mid_fill got=%0d exp=12", obs_ic_done - t0);
        end
    endtask

    task automatic test_rst_mid_fill();
        dc_a = 16'h4444; dc_req = 1'b1;
        repeat (6) step(1'b0);
        step(1'b1);
        dc_req = 1'b0;
        n_valid_seen = 0; n_we_seen = 0;
        repeat (8) step(1'b0);
        n_tests++;
        if (n_we_seen !== 0 || n_valid_seen !== 4) begin
            n_fail++;
            $display("FAIL rst_mid_fill got we=%0d valids=%0d exp we=0 valids=4", n_we_seen, n_valid_seen);
        end
    endtask

    task automatic test_back_to_back();
        int t0 = now;
        dc_a = 16'hFFF0; dc_req = 1'b1;
        repeat (14) step(1'b0);
        dc_a = 16'h0000; dc_req = 1'b1;
        repeat (16) step(1'b0);
        n_tests++;
        if (obs_dc_done !== t0 + 26) begin
            n_fail++;
            $display("FAIL back_to_back got=%0d exp=26", obs_dc_done - t0);
        end
    endtask

    task automatic test_random();
        rnd_mode = 1'b1;
        repeat (600) step(1'b0);
        rnd_mode = 1'b0;
        repeat (45) step(1'b0);
    endtask

    initial begin
        rnd_mode = 1'b0;
        obs_ic_done = -1; obs_dc_done = -1; obs_wr_done = -1;
        n_valid_seen = 0; n_we_seen = 0;
        test_reset();
        test_i_fill();
        test_store();
        test_conflict();
        test_store_then_fill();
        test_drop_mid_fill();
        test_rst_mid_fill();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
